vector_divide_seq: RTL and testbench
====================================

VECTOR_DIVIDE_SEQ -- requirements
Module: vector_divide_seq

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL have port CLK, input, 1, rising-edge clock.
REQ-003 SHALL have port nRST, input, 1, synchronous active-low reset.
REQ-004 SHALL have port vs1_data, input, 32, divisor; low SEW bits used.
REQ-005 SHALL have port vs2_data, input, 32, dividend; low SEW bits used.
REQ-006 SHALL have port sew, input, 2, element width: 0=8b, 1=16b, 2=32b; 3 is treated as 32b.
REQ-007 SHALL have port start_div, input, 1, request strobe, sampled only in IDLE.
REQ-008 SHALL have port div_type, input, 1, result select: 0=quotient, 1=remainder.
REQ-009 SHALL have port is_signed_div, input, 1, 1=two's-complement operands.
REQ-010 SHALL have port kill, input, 1, abort of the in-flight operation.
REQ-011 SHALL have port wdata_du, output, 32, result: SEW bits, upper bits zero.
REQ-012 SHALL have port busy_du, output, 1, operation in progress.
REQ-013 SHALL have port done_du, output, 1, one-cycle result-valid pulse.
REQ-014 SHALL have port exception_du, output, 1, always 0 (RVV division never traps).

Function
REQ-015 FSM SHALL have states IDLE, DIV, FIX, DONE.
REQ-016 In IDLE with start_div=1 (accept at cycle T), SHALL register operands, sew, div_type and is_signed_div. Later input changes SHALL NOT affect the operation.
REQ-017 On accept, SHALL compute W = 8/16/32 from sew and sign- or zero-extend operands from bit W-1 per is_signed_div.
REQ-018 Divisor == 0 SHALL bypass DIV and go straight to DONE at T+1 with quotient all-ones (W bits) and remainder = dividend (W bits).
REQ-019 Signed overflow (dividend = -2^(W-1), divisor = -1) SHALL bypass DIV and go to DONE at T+1 with quotient = dividend and remainder = 0.
REQ-020 Otherwise SHALL enter DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, W cycles (T+1..T+W), driven by an iteration counter.
REQ-021 FIX (T+W+1) SHALL negate the quotient if the operand signs differ (signed mode) and SHALL give the remainder the dividend's sign.
REQ-022 DONE (T+W+2) SHALL assert done_du=1 for exactly one cycle, then return to IDLE.
REQ-023 busy_du SHALL be 1 in DIV and FIX and 0 in IDLE and DONE.
REQ-024 wdata_du SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-025 wdata_du SHALL carry the selected result masked to W bits, with bits 31:W zero.
REQ-026 start_div outside IDLE, including in DONE, SHALL be ignored. A back-to-back accept is possible only at the cycle after DONE.
REQ-027 kill=1 in DIV or FIX SHALL go to IDLE next cycle: no done_du pulse, wdata_du unchanged. kill in IDLE/DONE SHALL have no effect except in the same cycle as start_div in IDLE, where kill wins and the request is dropped.
REQ-028 Total latency SHALL be W+2 cycles from accept to done_du in normal cases and 1 cycle for bypass cases.

Reset
REQ-029 nRST=0 at a clock edge SHALL force IDLE and set wdata_du=0, busy_du=0, done_du=0, exception_du=0, and clear counter and datapath registers.
REQ-030 Reset mid-operation SHALL discard the operation with no done_du pulse. start_div is ignored while nRST=0.

Verification
REQ-031 Unsigned, SEW32, 100/7, div_type=0, accept at T: busy_du high T+1..T+33; done_du at T+34; wdata_du=0x0000000E.
REQ-032 Signed, SEW32, -7/2, div_type=1: done_du at T+34; wdata_du=0xFFFFFFFF (remainder -1). Same operands with div_type=0: wdata_du=0xFFFFFFFD (-3).
REQ-033 Divide by zero, unsigned, SEW32, 5/0: done_du at T+1, busy_du never high, quotient wdata_du=0xFFFFFFFF; remainder request gives 0x00000005.
REQ-034 Signed overflow, SEW8, dividend 0x80, divisor 0xFF: done_du at T+1; quotient wdata_du=0x00000080; remainder wdata_du=0x00000000.
REQ-035 Unsigned, SEW8, 200/3, upper operand bits 0xFFFFFF: done_du at T+10; wdata_du=0x00000042. start_div asserted at T+5 is ignored.
REQ-036 kill at T+10 of a SEW32 op: IDLE at T+11; no done_du; wdata_du keeps its prior value. nRST=0 at T+5 of another op: all outputs 0 the next cycle.

Source files
------------

// File: rtl/vector_divide_seq.sv
// Sequential RVV integer divider: restoring radix-2 on magnitudes, one quotient bit per cycle,
// with single-cycle shortcuts for divide-by-zero and signed overflow.
module vector_divide_seq (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] vs1_data,
  input  logic [31:0] vs2_data,
  input  logic [1:0]  sew,
  input  logic        start_div,
  input  logic        div_type,
  input  logic        is_signed_div,
  input  logic        kill,
  output logic [31:0] wdata_du,
  output logic        busy_du,
  output logic        done_du,
  output logic        exception_du
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t      state_reg;
  logic [31:0] dvs_reg, dvd_reg, rem_reg, quo_reg, mask_reg, wdata_reg;
  logic [4:0]  cnt_reg;
  logic        q_neg_reg, r_neg_reg, div_type_reg, busy_reg, done_reg;

  logic [31:0] w_mask, dvs_ext, dvd_ext, dvs_mag, dvd_mag, bypass_res;
  logic [4:0]  cnt_init;
  logic        dvs_neg, dvd_neg, div_zero, overflow;

  // Operand decode for the accept cycle: element width, extension, shortcut detection.
  always_comb begin
    w_mask   = 32'hFFFF_FFFF;
    cnt_init = 5'd31;
    dvs_ext  = vs1_data;
    dvd_ext  = vs2_data;
    case (sew)
      2'd0: begin
        w_mask   = 32'h0000_00FF;
        cnt_init = 5'd7;
        dvs_ext  = {{24{is_signed_div & vs1_data[7]}}, vs1_data[7:0]};
        dvd_ext  = {{24{is_signed_div & vs2_data[7]}}, vs2_data[7:0]};
      end
      2'd1: begin
        w_mask   = 32'h0000_FFFF;
        cnt_init = 5'd15;
        dvs_ext  = {{16{is_signed_div & vs1_data[15]}}, vs1_data[15:0]};
        dvd_ext  = {{16{is_signed_div & vs2_data[15]}}, vs2_data[15:0]};
      end
      default: ;
    endcase
    dvs_neg  = is_signed_div & dvs_ext[31];
    dvd_neg  = is_signed_div & dvd_ext[31];
    dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
    dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
    div_zero = (dvs_ext == 32'd0);
    // Most negative W-bit value, sign-extended, is the complement of mask>>1.
    overflow = is_signed_div && (dvd_ext == ~(w_mask >> 1)) && (dvs_ext == 32'hFFFF_FFFF);
    if (div_zero)
      bypass_res = div_type ? (dvd_ext & w_mask) : w_mask;
    else
      bypass_res = div_type ? 32'd0 : (dvd_ext & w_mask);
  end

  logic [32:0] rem_shift, rem_sub;
  logic        q_bit;
  logic [31:0] q_fix, r_fix, fix_res;

  always_comb begin
    rem_shift = {rem_reg, dvd_reg[cnt_reg]};
    q_bit     = (rem_shift >= {1'b0, dvs_reg});
    rem_sub   = q_bit ? (rem_shift - {1'b0, dvs_reg}) : rem_shift;
    q_fix     = q_neg_reg ? -quo_reg : quo_reg;
    r_fix     = r_neg_reg ? -rem_reg : rem_reg;
    fix_res   = (div_type_reg ? r_fix : q_fix) & mask_reg;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      dvs_reg      <= '0;
      dvd_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      mask_reg     <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      div_type_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_div && !kill) begin
            dvs_reg      <= dvs_mag;
            dvd_reg      <= dvd_mag;
            mask_reg     <= w_mask;
            div_type_reg <= div_type;
            q_neg_reg    <= dvs_neg ^ dvd_neg;
            r_neg_reg    <= dvd_neg;
            rem_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= cnt_init;
            if (div_zero || overflow) begin
              wdata_reg <= bypass_res;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          if (kill) begin
            state_reg <= IDLE;
          end else begin
            rem_reg  <= rem_sub[31:0];
            quo_reg  <= {quo_reg[30:0], q_bit};
            cnt_reg  <= cnt_reg - 5'd1;
            busy_reg <= 1'b1;
            if (cnt_reg == 5'd0)
              state_reg <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            state_reg <= IDLE;
          end else begin
            wdata_reg <= fix_res;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wdata_du     = wdata_reg;
  assign busy_du      = busy_reg;
  assign done_du      = done_reg;
  assign exception_du = 1'b0;

endmodule

// File: tb/tb_vector_divide_seq.sv
// Bench for vector_divide_seq: directed table, hand-written kill/reset/DONE sequences,
// and random operations checked against an arithmetic reference model.
module tb_vector_divide_seq;

  logic        CLK, nRST;
  logic [31:0] vs1_data, vs2_data;
  logic [1:0]  sew;
  logic        start_div, div_type, is_signed_div, kill;
  logic [31:0] wdata_du;
  logic        busy_du, done_du, exception_du;

  int n_vec = 0;
  int n_bad = 0;

  vector_divide_seq dut (
    .CLK(CLK), .nRST(nRST), .vs1_data(vs1_data), .vs2_data(vs2_data), .sew(sew),
    .start_div(start_div), .div_type(div_type), .is_signed_div(is_signed_div), .kill(kill),
    .wdata_du(wdata_du), .busy_du(busy_du), .done_du(done_du), .exception_du(exception_du)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sew;
    logic        sgn;
    logic        typ;
    logic [31:0] vs1;
    logic [31:0] vs2;
    logic [31:0] exp;
    int          lat;
    int          poke;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on W-bit values with RVV division rules.
  function automatic logic [31:0] ref_div(input logic [1:0] s, input logic sg, input logic ty,
                                          input logic [31:0] d1, input logic [31:0] d2,
                                          output int lat);
    int w;
    longint m, a, b, q, r;
    w = (s == 2'd0) ? 8 : (s == 2'd1) ? 16 : 32;
    m = (longint'(1) << w) - 1;
    a = longint'(d1) & m;
    b = longint'(d2) & m;
    if (sg && ((a >> (w - 1)) & 1) == 1) a = a - (longint'(1) << w);
    if (sg && ((b >> (w - 1)) & 1) == 1) b = b - (longint'(1) << w);
    if (a == 0) begin
      q = -1; r = b; lat = 1;
    end else if (sg && a == -1 && b == -(longint'(1) << (w - 1))) begin
      q = b; r = 0; lat = 1;
    end else begin
      q = b / a; r = b % a; lat = w + 2;
    end
    return 32'((ty ? r : q) & m);
  endfunction

  task automatic run_op(input string tag, input logic [1:0] s, input logic sg, input logic ty,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] exp,
                        input int exp_lat, input int poke);
    int lat, busy_cnt;
    sew = s; is_signed_div = sg; div_type = ty; vs1_data = d1; vs2_data = d2;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    vs1_data = $urandom; vs2_data = $urandom; sew = 2'($urandom);
    div_type = 1'($urandom); is_signed_div = 1'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done_du && lat < 60) begin
      busy_cnt += int'(busy_du);
      @(negedge CLK);
      lat++;
      start_div = (poke != 0 && lat == poke);
    end
    start_div = 1'b0;
    chk({tag, " done"}, 32'(done_du), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " wdata"}, wdata_du, exp);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'((exp_lat == 1) ? 0 : exp_lat - 1));
    chk({tag, " busy at done"}, 32'(busy_du), 32'd0);
    chk({tag, " exception"}, 32'(exception_du), 32'd0);
    $display("op %s sew=%0d sgn=%0d typ=%0d vs1=%h vs2=%h -> wdata=%h lat=%0d",
             tag, s, sg, ty, d1, d2, wdata_du, lat);
    @(negedge CLK);
    chk({tag, " done one cycle"}, 32'(done_du), 32'd0);
  endtask

  vec_t tbl[11];
  logic [31:0] prev;

  initial begin
    int done_seen, elat, guard;
    logic [1:0]  rs;
    logic        rsg, rty;
    logic [31:0] r1, r2, rexp;

    tbl[0]  = '{2'd2, 1'b0, 1'b0, 32'd7,         32'd100,       32'h0000_000E, 34, 0};
    tbl[1]  = '{2'd2, 1'b1, 1'b1, 32'd2,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 34, 0};
    tbl[2]  = '{2'd2, 1'b1, 1'b0, 32'd2,         32'hFFFF_FFF9, 32'hFFFF_FFFD, 34, 0};
    tbl[3]  = '{2'd2, 1'b0, 1'b0, 32'd0,         32'd5,         32'hFFFF_FFFF, 1,  0};
    tbl[4]  = '{2'd2, 1'b0, 1'b1, 32'd0,         32'd5,         32'h0000_0005, 1,  0};
    tbl[5]  = '{2'd0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0080, 32'h0000_0080, 1,  0};
    tbl[6]  = '{2'd0, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0080, 32'h0000_0000, 1,  0};
    tbl[7]  = '{2'd0, 1'b0, 1'b0, 32'hFFFF_FF03, 32'hFFFF_FFC8, 32'h0000_0042, 10, 5};
    tbl[8]  = '{2'd1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_FF9C, 32'h0000_FFF2, 18, 0};
    tbl[9]  = '{2'd0, 1'b1, 1'b1, 32'h1234_5600, 32'h0000_0085, 32'h0000_0085, 1,  0};
    tbl[10] = '{2'd3, 1'b0, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 34, 0};

    nRST = 1'b0; start_div = 1'b1; kill = 1'b0; sew = 2'd2; div_type = 1'b0;
    is_signed_div = 1'b0; vs1_data = 32'd0; vs2_data = 32'd5;
    repeat (3) @(negedge CLK);
    chk("reset wdata", wdata_du, 32'd0);
    chk("reset busy", 32'(busy_du), 32'd0);
    chk("reset done", 32'(done_du), 32'd0);
    chk("reset exception", 32'(exception_du), 32'd0);
    start_div = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].sew, tbl[i].sgn, tbl[i].typ, tbl[i].vs1,
             tbl[i].vs2, tbl[i].exp, tbl[i].lat, tbl[i].poke);
    prev = tbl[10].exp;

    // Kill in DIV at T+10: back to IDLE, no pulse, result register untouched.
    sew = 2'd2; is_signed_div = 1'b0; div_type = 1'b0; vs1_data = 32'd3; vs2_data = 32'd1000;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    repeat (9) @(negedge CLK);
    kill = 1'b1;
    @(negedge CLK);
    kill = 1'b0;
    chk("kill busy", 32'(busy_du), 32'd0);
    done_seen = 0;
    repeat (40) begin
      done_seen += int'(done_du);
      @(negedge CLK);
    end
    chk("kill no done", 32'(done_seen), 32'd0);
    chk("kill wdata kept", wdata_du, prev);
    $display("op kill-in-div wdata=%h", wdata_du);

    // Kill together with start in IDLE drops the request (bypass op would pulse next cycle).
    vs1_data = 32'd0; vs2_data = 32'd9; start_div = 1'b1; kill = 1'b1;
    @(negedge CLK);
    start_div = 1'b0; kill = 1'b0;
    chk("kill+start done", 32'(done_du), 32'd0);
    chk("kill+start busy", 32'(busy_du), 32'd0);
    repeat (3) @(negedge CLK);
    chk("kill+start wdata", wdata_du, prev);
    $display("op kill-with-start wdata=%h", wdata_du);

    // start_div during DONE is ignored.
    sew = 2'd0; is_signed_div = 1'b0; div_type = 1'b0; vs1_data = 32'd2; vs2_data = 32'd9;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    guard = 0;
    while (!done_du && guard < 60) begin
      @(negedge CLK);
      guard++;
    end
    chk("done-start reached done", 32'(done_du), 32'd1);
    chk("done-start wdata", wdata_du, 32'd4);
    vs1_data = 32'd0; start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    chk("start in DONE done", 32'(done_du), 32'd0);
    chk("start in DONE busy", 32'(busy_du), 32'd0);
    @(negedge CLK);
    chk("start in DONE later done", 32'(done_du), 32'd0);
    $display("op start-in-done wdata=%h", wdata_du);

    // Reset at T+5 of an operation.
    sew = 2'd2; vs1_data = 32'd5; vs2_data = 32'd77; start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    repeat (4) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    chk("midreset wdata", wdata_du, 32'd0);
    chk("midreset busy", 32'(busy_du), 32'd0);
    chk("midreset done", 32'(done_du), 32'd0);
    nRST = 1'b1;
    done_seen = 0;
    repeat (40) begin
      done_seen += int'(done_du);
      @(negedge CLK);
    end
    chk("midreset no done", 32'(done_seen), 32'd0);
    $display("op reset-mid-op wdata=%h", wdata_du);

    for (int i = 0; i < 60; i++) begin
      rs = 2'($urandom); rsg = 1'($urandom); rty = 1'($urandom);
      r1 = $urandom; r2 = $urandom;
      case ($urandom_range(0, 5))
        0: r1 = r1 & 32'hFFFF_FF00 & ~32'h0000_FF00 & ~32'hFFFF_0000;
        1: r1 = 32'hFFFF_FFFF;
        2: begin r1 = 32'hFFFF_FFFF;
                 r2 = (rs == 2'd0) ? 32'h0000_0080 : (rs == 2'd1) ? 32'h0000_8000 : 32'h8000_0000; end
        3: r1 = $urandom_range(1, 20);
        default: ;
      endcase
      rexp = ref_div(rs, rsg, rty, r1, r2, elat);
      run_op($sformatf("rnd%0d", i), rs, rsg, rty, r1, r2, rexp, elat, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
